square_scheduler: RTL

Time-shares one `square` instance across N_CH sample channels in the threshold-cutter path, one issue per cycle.
- Arbitrates per-channel valid/ready requests round-robin and drives the shared unit's src0/src1 with the granted sample.
- Tags each issued operation with its channel, tracks it through the unit's fixed latency, and emits the squared result with that tag.

---
 rtl/square_scheduler_if.sv | 44 ++++
 rtl/square_scheduler.sv | 98 +++++++++
 2 files changed

// File: rtl/square_scheduler_if.sv
// -----------------------------------------------------------------------------
// square_scheduler_if
// Bundles the request, shared-multiplier and result signals of square_scheduler.
//   clr        : synchronous flush request
//   ch_en      : per-channel enable mask
//   req_valid  : per-channel sample valid
//   req_data   : per-channel samples, channel i at [i*W +: W]
//   req_ready  : one-hot grant back to the channels
//   mul_src0/1 : operands to the shared square unit
//   mul_res    : result from the shared square unit
//   res_valid  : one-cycle result strobe
//   res_ch     : channel tag of the result
//   res_data   : unsigned square of the sample
//   busy       : any operation in flight
// master = environment (channels, square unit, consumer); slave = scheduler.
// -----------------------------------------------------------------------------
interface square_scheduler_if #(
   parameter int SRC_DATA_WIDTH = 16,
   parameter int N_CH           = 4,
   parameter int CH_W           = 2
);
   logic                           clr;
   logic [N_CH-1:0]                ch_en;
   logic [N_CH-1:0]                req_valid;
   logic [N_CH*SRC_DATA_WIDTH-1:0] req_data;
   logic [N_CH-1:0]                req_ready;
   logic [SRC_DATA_WIDTH-1:0]      mul_src0;
   logic [SRC_DATA_WIDTH-1:0]      mul_src1;
   logic [2*SRC_DATA_WIDTH-1:0]    mul_res;
   logic                           res_valid;
   logic [CH_W-1:0]                res_ch;
   logic [2*SRC_DATA_WIDTH-1:0]    res_data;
   logic                           busy;

   modport master (
      output clr, ch_en, req_valid, req_data, mul_res,
      input  req_ready, mul_src0, mul_src1, res_valid, res_ch, res_data, busy
   );

   modport slave (
      input  clr, ch_en, req_valid, req_data, mul_res,
      output req_ready, mul_src0, mul_src1, res_valid, res_ch, res_data, busy
   );
endinterface

// File: rtl/square_scheduler.sv
// -----------------------------------------------------------------------------
// square_scheduler
// Time-shares one square unit across N_CH sample channels. A round-robin
// arbiter grants one channel per cycle, the granted sample is registered onto
// the unit's operands, and a tag pipeline matching the unit latency carries the
// channel index so each result leaves with its tag, in acceptance order.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : square_scheduler_if.slave (request, multiplier and result signals)
// -----------------------------------------------------------------------------
module square_scheduler #(
   parameter int SRC_DATA_WIDTH = 16,
   parameter int N_CH           = 4,
   parameter int CH_W           = 2,
   parameter int MUL_LATENCY    = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   square_scheduler_if.slave  bus
);
   localparam int W = SRC_DATA_WIDTH;
   localparam int L = MUL_LATENCY;

   logic [N_CH-1:0]       w_elig;
   logic [N_CH-1:0]       w_grant;
   logic [CH_W-1:0]       w_gnt_idx;
   logic                  w_xfer;

   logic [CH_W-1:0]       r_rr_ptr;
   logic [W-1:0]          r_iss_data;
   // r_vld_pipe[0] is the issue-stage valid; stage L lines up with mul_res.
   logic [L:0]            r_vld_pipe;
   logic [L:0][CH_W-1:0]  r_tag_pipe;
   logic                  r_res_valid;
   logic [CH_W-1:0]       r_res_ch;
   logic [2*W-1:0]        r_res_data;

   // Scan from the pointer upward with wrap; the first eligible channel wins.
   // A grant implies valid, so a grant is always a transfer.
   always_comb begin
      int idx;
      w_elig    = bus.req_valid & bus.ch_en;
      w_grant   = '0;
      w_gnt_idx = '0;
      w_xfer    = 1'b0;
      idx       = 0;
      for (int k = 0; k < N_CH; k++) begin
         idx = int'(r_rr_ptr) + k;
         if (idx >= N_CH) idx = idx - N_CH;
         if (!w_xfer && !bus.clr && w_elig[idx]) begin
            w_xfer       = 1'b1;
            w_gnt_idx    = CH_W'(idx);
            w_grant[idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr    <= '0;
         r_iss_data  <= '0;
         r_vld_pipe  <= '0;
         r_tag_pipe  <= '0;
         r_res_valid <= 1'b0;
         r_res_ch    <= '0;
         r_res_data  <= '0;
      end else if (bus.clr) begin
         // Flush drops every in-flight op; result data/tag hold their last value.
         r_rr_ptr    <= '0;
         r_vld_pipe  <= '0;
         r_res_valid <= 1'b0;
      end else begin
         if (w_xfer) begin
            r_rr_ptr      <= (w_gnt_idx == CH_W'(N_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
            r_iss_data    <= bus.req_data[w_gnt_idx*W +: W];
            r_tag_pipe[0] <= w_gnt_idx;
         end
         r_vld_pipe[0] <= w_xfer;
         for (int s = 1; s <= L; s++) begin
            r_vld_pipe[s] <= r_vld_pipe[s-1];
            r_tag_pipe[s] <= r_tag_pipe[s-1];
         end
         r_res_valid <= r_vld_pipe[L];
         if (r_vld_pipe[L]) begin
            r_res_data <= bus.mul_res;
            r_res_ch   <= r_tag_pipe[L];
         end
      end
   end

   assign bus.req_ready = w_grant;
   assign bus.mul_src0  = r_iss_data;
   assign bus.mul_src1  = r_iss_data;
   assign bus.res_valid = r_res_valid;
   assign bus.res_ch    = r_res_ch;
   assign bus.res_data  = r_res_data;
   assign bus.busy      = (|r_vld_pipe) | r_res_valid;
endmodule
